// File: rtl/mips_register_writeback_file.sv
// MIPS register file with write-back commit, same-cycle bypass and
// per-register pending-write counters that stall decode on unsafe operands
// or a saturated destination.
module mips_register_writeback_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int PENDING_MAX = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issueValid,
    output logic                  issueReady,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic                  port1AddrSource,
    input  logic                  port2AddrSource,
    input  logic [1:0]            writeAddrSource,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] read1Data,
    output logic [DATA_WIDTH-1:0] read2Data,
    output logic [4:0]            issueWriteAddr,
    input  logic                  wbValid,
    input  logic [4:0]            wbAddr,
    input  logic [1:0]            wbDataSource,
    input  logic [DATA_WIDTH-1:0] wbAlu,
    input  logic [DATA_WIDTH-1:0] wbMemory,
    input  logic [DATA_WIDTH-1:0] wbPc,
    output logic                  pendingError
);

    localparam int CW = $clog2(PENDING_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PENDING_MAX);

    logic [DATA_WIDTH-1:0] regs [32];
    logic [CW-1:0]         cnt  [32];

    logic [4:0]            a1;
    logic [4:0]            a2;
    logic [4:0]            dest;
    logic [DATA_WIDTH-1:0] wbData;
    logic                  busy1;
    logic                  busy2;
    logic                  destFull;
    logic                  issueFire;

    // Resolve read/destination addresses and select the write-back data source
    always_comb begin
        a1 = port1AddrSource ? rt : rs;
        a2 = port2AddrSource ? rs : rt;
        dest = rt;
        case (writeAddrSource)
            2'd1:    dest = rd;
            2'd2:    dest = 5'd31;
            default: dest = rt;
        endcase
        if (!writeEnable) dest = 5'd0;
        case (wbDataSource)
            2'd1:    wbData = wbMemory;
            2'd2:    wbData = wbPc;
            default: wbData = wbAlu;
        endcase
    end

    // Operand reads: register 0 is hard zero, a same-cycle write-back wins over the array
    always_comb begin
        read1Data = regs[a1];
        if (wbValid && wbAddr == a1) read1Data = wbData;
        if (a1 == 5'd0) read1Data = '0;
        read2Data = regs[a2];
        if (wbValid && wbAddr == a2) read2Data = wbData;
        if (a2 == 5'd0) read2Data = '0;
    end

    // Hazard detection; a final write-back landing this cycle releases its consumer immediately
    always_comb begin
        busy1 = (a1 != 5'd0) && (cnt[a1] != '0) &&
                !((cnt[a1] == CW'(1)) && wbValid && (wbAddr == a1));
        busy2 = (a2 != 5'd0) && (cnt[a2] != '0) &&
                !((cnt[a2] == CW'(1)) && wbValid && (wbAddr == a2));
        destFull = (dest != 5'd0) && (cnt[dest] == CNT_MAX) &&
                   !(wbValid && (wbAddr == dest));
        issueReady = !reset && !busy1 && !busy2 && !destFull;
        issueFire = issueValid && issueReady && (dest != 5'd0);
        issueWriteAddr = dest;
    end

    // Commit write-backs, track outstanding writes and latch the sticky underflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            pendingError <= 1'b0;
        end else begin
            if (wbValid && wbAddr != 5'd0) begin
                regs[wbAddr] <= wbData;
                if (cnt[wbAddr] == '0) pendingError <= 1'b1;
            end
            for (int i = 1; i < 32; i++) begin
                if ((issueFire && dest == 5'(i)) &&
                    !(wbValid && wbAddr == 5'(i) && cnt[i] != '0))
                    cnt[i] <= cnt[i] + CW'(1);
                else if (!(issueFire && dest == 5'(i)) &&
                         (wbValid && wbAddr == 5'(i) && cnt[i] != '0))
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

endmodule
